// File: rtl/leaf_out_arbiter.sv
// Round-robin scheduler that shares the leaf-to-BFT packet channel among the user
// output streams, gating each port on destination credits and stamping leaf/port/address.
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  bft_rdy,
  input  logic                                  resend,
  input  logic                                  cfg_vld,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dport,
  input  logic                                  upd_vld,
  input  logic [NUM_PORT_BITS-1:0]              upd_port
);

  localparam int CW = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(1 << NUM_BRAM_ADDR_BITS);
  localparam logic [CW:0] CREDIT_UPD = (CW+1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [NUM_PORT_BITS-1:0] PTR_INIT = NUM_PORT_BITS'(NUM_OUT_PORTS - 1);

  logic                          en_q     [NUM_OUT_PORTS];
  logic                          en_d     [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]      leaf_q   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]      leaf_d   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]      dport_q  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]      dport_d  [NUM_OUT_PORTS];
  logic [CW-1:0]                 credit_q [NUM_OUT_PORTS];
  logic [CW-1:0]                 credit_d [NUM_OUT_PORTS];
  logic [NUM_BRAM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
  logic [NUM_BRAM_ADDR_BITS-1:0] addr_d   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]      ptr_q, ptr_d;
  logic [PACKET_BITS-1:0]        pkt_q, pkt_d;

  logic [NUM_OUT_PORTS-1:0] elig_s;
  logic [NUM_OUT_PORTS-1:0] gnt_s;
  logic                     grant_ok_s;
  logic                     grant_s;
  logic                     hi_found_s;
  logic                     lo_found_s;
  logic [NUM_PORT_BITS-1:0] hi_win_s;
  logic [NUM_PORT_BITS-1:0] lo_win_s;
  logic [NUM_PORT_BITS-1:0] win_s;
  logic [PACKET_BITS-1:0]   sel_pkt_s;

  // Round-robin pick: ports above ptr take precedence, then wrap to ports at or below it.
  always_comb begin
    elig_s     = '0;
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_win_s   = '0;
    lo_win_s   = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig_s[i]  = en_q[i] & vld_user2interface[i] & (credit_q[i] != '0);
      hi_win_s   = (elig_s[i] && !hi_found_s && (i > int'(ptr_q))) ? NUM_PORT_BITS'(i) : hi_win_s;
      hi_found_s = hi_found_s | (elig_s[i] & (i > int'(ptr_q)));
      lo_win_s   = (elig_s[i] && !lo_found_s && (i <= int'(ptr_q))) ? NUM_PORT_BITS'(i) : lo_win_s;
      lo_found_s = lo_found_s | (elig_s[i] & (i <= int'(ptr_q)));
    end
    grant_ok_s = reset & ~resend & (~pkt_q[PACKET_BITS-1] | bft_rdy);
    grant_s    = grant_ok_s & (hi_found_s | lo_found_s);
    win_s      = hi_found_s ? hi_win_s : lo_win_s;
    gnt_s      = '0;
    sel_pkt_s  = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      gnt_s[i]  = grant_s & (win_s == NUM_PORT_BITS'(i));
      sel_pkt_s = gnt_s[i] ? {1'b1, leaf_q[i], dport_q[i], addr_q[i],
                              din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]}
                           : sel_pkt_s;
    end
  end

  // Next-state for the output register, pointer and per-port configuration/credit state.
  always_comb begin
    logic [CW:0] credit_sum_v;
    logic        cfg_hit_v;
    logic        upd_hit_v;
    ptr_d = grant_s ? win_s : ptr_q;
    if (resend) begin
      pkt_d = pkt_q;
    end else if (grant_s) begin
      pkt_d = sel_pkt_s;
    end else if (bft_rdy) begin
      pkt_d = '0;
    end else begin
      pkt_d = pkt_q;
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cfg_hit_v    = cfg_vld & (cfg_port == NUM_PORT_BITS'(i));
      upd_hit_v    = upd_vld & (upd_port == NUM_PORT_BITS'(i));
      credit_sum_v = {1'b0, credit_q[i]} + (upd_hit_v ? CREDIT_UPD : (CW+1)'(0))
                     - (CW+1)'(gnt_s[i]);
      if (cfg_hit_v) begin
        en_d[i]     = 1'b1;
        leaf_d[i]   = cfg_leaf;
        dport_d[i]  = cfg_dport;
        credit_d[i] = CREDIT_MAX;
        addr_d[i]   = '0;
      end else begin
        en_d[i]     = en_q[i];
        leaf_d[i]   = leaf_q[i];
        dport_d[i]  = dport_q[i];
        credit_d[i] = (credit_sum_v > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : credit_sum_v[CW-1:0];
        addr_d[i]   = addr_q[i] + NUM_BRAM_ADDR_BITS'(gnt_s[i]);
      end
    end
  end

  // State registers with synchronous active-low reset; a held packet is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= PTR_INIT;
      pkt_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        en_q[i]     <= 1'b0;
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
        credit_q[i] <= CREDIT_MAX;
        addr_q[i]   <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      pkt_q    <= pkt_d;
      en_q     <= en_d;
      leaf_q   <= leaf_d;
      dport_q  <= dport_d;
      credit_q <= credit_d;
      addr_q   <= addr_d;
    end
  end

  assign ack_interface2user      = gnt_s;
  assign dout_leaf_interface2bft = resend ? '0 : pkt_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Self-checking bench for leaf_out_arbiter: a vector table for the basic path plus
// scoreboarded sequences for round-robin, back-pressure, resend, reset and credits.
module tb_leaf_out_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] din_leaf_user2interface;
  logic [1:0]  vld_user2interface;
  logic [1:0]  ack_interface2user;
  logic [48:0] dout_leaf_interface2bft;
  logic        bft_rdy;
  logic        resend;
  logic        cfg_vld;
  logic [3:0]  cfg_port;
  logic [4:0]  cfg_leaf;
  logic [3:0]  cfg_dport;
  logic        upd_vld;
  logic [3:0]  upd_port;

  always #5 clk = ~clk;

  leaf_out_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din_leaf_user2interface),
    .vld_user2interface      (vld_user2interface),
    .ack_interface2user      (ack_interface2user),
    .dout_leaf_interface2bft (dout_leaf_interface2bft),
    .bft_rdy                 (bft_rdy),
    .resend                  (resend),
    .cfg_vld                 (cfg_vld),
    .cfg_port                (cfg_port),
    .cfg_leaf                (cfg_leaf),
    .cfg_dport               (cfg_dport),
    .upd_vld                 (upd_vld),
    .upd_port                (upd_port)
  );

  typedef struct {
    logic        cv;
    logic [3:0]  cp;
    logic [4:0]  cl;
    logic [3:0]  cd;
    logic [1:0]  vld;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
    logic [1:0]  e_ack;
    logic [48:0] e_dout;
  } vec_t;

  vec_t        tbl [9];
  int          checks = 0;
  int          failures = 0;
  logic [48:0] exp_q [$];
  logic [4:0]  b_leaf  [2];
  logic [3:0]  b_dport [2];
  logic [6:0]  b_addr  [2];
  logic [31:0] b_seq   [2];
  int          nxt;

  function automatic logic [48:0] mk_pkt(input logic [4:0] l, input logic [3:0] d,
                                         input logic [6:0] a, input logic [31:0] p);
    return {1'b1, l, d, a, p};
  endfunction

  function automatic logic [31:0] data_of(input int p, input logic [31:0] s);
    return {4'hA, 4'(p), s[23:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int p = 0; p < 2; p++) begin
      b_addr[p] = 7'd0;
      b_seq[p]  = 32'd0;
    end
    nxt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    vld_user2interface = 2'b00;
    cfg_vld = 1'b0;
    upd_vld = 1'b0;
    resend  = 1'b0;
    bft_rdy = 1'b1;
    tick();
    reset = 1'b1;
    clear_model();
  endtask

  // One scoreboarded cycle: compare ack and dout, then queue the next expected register.
  task automatic step(input logic [1:0] exp_ack, input string nm);
    logic [48:0] reg_e;
    din_leaf_user2interface[31:0]  = data_of(0, b_seq[0]);
    din_leaf_user2interface[63:32] = data_of(1, b_seq[1]);
    #2;
    reg_e = (exp_q.size() != 0) ? exp_q.pop_front() : 49'd0;
    chk({nm, " ack"}, 64'(ack_interface2user), 64'(exp_ack));
    chk({nm, " dout"}, 64'(dout_leaf_interface2bft), resend ? 64'd0 : 64'(reg_e));
    if (resend) begin
      exp_q.push_back(reg_e);
    end else if (exp_ack != 2'b00) begin
      int p;
      p = exp_ack[1] ? 1 : 0;
      exp_q.push_back(mk_pkt(b_leaf[p], b_dport[p], b_addr[p], data_of(p, b_seq[p])));
      b_addr[p] = b_addr[p] + 7'd1;
      b_seq[p]  = b_seq[p] + 32'd1;
    end else if (bft_rdy) begin
      exp_q.push_back(49'd0);
    end else begin
      exp_q.push_back(reg_e);
    end
    tick();
  endtask

  task automatic rr_step(input string nm);
    step((nxt == 0) ? 2'b01 : 2'b10, nm);
    nxt = 1 - nxt;
  endtask

  task automatic cfg(input logic [3:0] p, input logic [4:0] l, input logic [3:0] d);
    cfg_vld = 1'b1;
    cfg_port = p;
    cfg_leaf = l;
    cfg_dport = d;
    if (p < 4'd2) begin
      b_leaf[p[0]]  = l;
      b_dport[p[0]] = d;
      b_addr[p[0]]  = 7'd0;
    end else begin
      b_leaf[0] = b_leaf[0];
    end
    step(2'b00, "cfg");
    cfg_vld = 1'b0;
  endtask

  initial begin
    reset = 1'b0; din_leaf_user2interface = 64'd0; vld_user2interface = 2'b00;
    bft_rdy = 1'b1; resend = 1'b0; cfg_vld = 1'b0; cfg_port = 4'd0; cfg_leaf = 5'd0;
    cfg_dport = 4'd0; upd_vld = 1'b0; upd_port = 4'd0;
    b_leaf[0] = 5'd0; b_leaf[1] = 5'd0; b_dport[0] = 4'd0; b_dport[1] = 4'd0;
    tick();
    do_reset();

    tbl[0] = '{1'b1, 4'd0, 5'd3,  4'd2,  2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 49'd0};
    tbl[1] = '{1'b0, 4'd0, 5'd0,  4'd0,  2'b01, 32'hDEADBEEF, 32'h0,        1'b1, 2'b01, 49'd0};
    tbl[2] = '{1'b0, 4'd0, 5'd0,  4'd0,  2'b00, 32'h0,        32'h0,        1'b1, 2'b00,
               mk_pkt(5'd3, 4'd2, 7'd0, 32'hDEADBEEF)};
    tbl[3] = '{1'b1, 4'd2, 5'd31, 4'd15, 2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 49'd0};
    tbl[4] = '{1'b1, 4'd1, 5'd7,  4'd5,  2'b00, 32'h0,        32'h0,        1'b1, 2'b00, 49'd0};
    tbl[5] = '{1'b0, 4'd0, 5'd0,  4'd0,  2'b11, 32'h11111111, 32'h22222222, 1'b1, 2'b10, 49'd0};
    tbl[6] = '{1'b0, 4'd0, 5'd0,  4'd0,  2'b11, 32'h11111111, 32'h33333333, 1'b1, 2'b01,
               mk_pkt(5'd7, 4'd5, 7'd0, 32'h22222222)};
    tbl[7] = '{1'b0, 4'd0, 5'd0,  4'd0,  2'b00, 32'h0,        32'h0,        1'b1, 2'b00,
               mk_pkt(5'd3, 4'd2, 7'd1, 32'h11111111)};
    tbl[8] = '{1'b0, 4'd0, 5'd0,  4'd0,  2'b00, 32'h0,        32'h0,        1'b0, 2'b00, 49'd0};
    for (int r = 0; r < 9; r++) begin
      cfg_vld = tbl[r].cv; cfg_port = tbl[r].cp; cfg_leaf = tbl[r].cl; cfg_dport = tbl[r].cd;
      vld_user2interface = tbl[r].vld; bft_rdy = tbl[r].rdy;
      din_leaf_user2interface = {tbl[r].d1, tbl[r].d0};
      #2;
      chk($sformatf("tbl%0d ack", r), 64'(ack_interface2user), 64'(tbl[r].e_ack));
      chk($sformatf("tbl%0d dout", r), 64'(dout_leaf_interface2bft), 64'(tbl[r].e_dout));
      tick();
    end
    cfg_vld = 1'b0;

    // Round-robin alternation, then back-pressure and resend mid-stream.
    do_reset();
    vld_user2interface = 2'b11;
    step(2'b00, "post-reset");
    vld_user2interface = 2'b00;
    cfg(4'd0, 5'd1, 4'd1);
    cfg(4'd1, 5'd2, 4'd3);
    vld_user2interface = 2'b11;
    for (int k = 0; k < 8; k++) rr_step("alternate");
    bft_rdy = 1'b0;
    for (int k = 0; k < 5; k++) step(2'b00, "hold");
    bft_rdy = 1'b1;
    rr_step("rdy resume");
    rr_step("after resume");
    resend = 1'b1;
    for (int k = 0; k < 3; k++) step(2'b00, "resend");
    resend = 1'b0;
    rr_step("resend release");
    vld_user2interface = 2'b00;
    step(2'b00, "drain");
    step(2'b00, "idle");

    // Reset during back-to-back traffic discards everything and disables ports.
    vld_user2interface = 2'b11;
    rr_step("pre-reset a");
    rr_step("pre-reset b");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    clear_model();
    step(2'b00, "mid-reset a");
    step(2'b00, "mid-reset b");
    vld_user2interface = 2'b00;
    cfg(4'd1, 5'd9, 4'd4);
    vld_user2interface = 2'b11;
    step(2'b10, "reconf p1 a");
    step(2'b10, "reconf p1 b");
    vld_user2interface = 2'b00;
    step(2'b00, "reconf drain");

    // Credit exhaustion, ignored/valid updates, address wrap and saturation.
    do_reset();
    cfg(4'd0, 5'd4, 4'd1);
    vld_user2interface = 2'b01;
    for (int k = 0; k < 128; k++) step(2'b01, "credit word");
    step(2'b00, "credit empty");
    upd_vld = 1'b1; upd_port = 4'd2;
    step(2'b00, "upd bad port");
    upd_port = 4'd0;
    step(2'b00, "upd cycle");
    upd_vld = 1'b0;
    for (int k = 0; k < 64; k++) step(2'b01, "refill word");
    step(2'b00, "refill empty");
    upd_vld = 1'b1;
    step(2'b00, "upd again");
    step(2'b01, "upd with grant");
    upd_vld = 1'b0;
    for (int k = 0; k < 127; k++) step(2'b01, "net63 word");
    step(2'b00, "net63 empty");
    vld_user2interface = 2'b00;
    step(2'b00, "final drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Round-robin output scheduler inside the leaf shell. It shares the single 49-bit leaf-to-BFT packet channel between NUM_OUT_PORTS user output streams, using the vld/ack handshake on the user side. For each port it gates traffic on a per-destination credit counter and stamps destination leaf, destination port and a wrapping BRAM write address into every packet. It runs in the 400 MHz interface domain.

## Interface
Parameters:
- PACKET_BITS, 49, packet width
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 5, destination-leaf field width
- NUM_PORT_BITS, 4, destination-port field width
- NUM_BRAM_ADDR_BITS, 7, address field width; destination buffer depth = 2^7 = 128
- NUM_OUT_PORTS, 2, number of user output streams (1..15)
- FREESPACE_UPDATE_SIZE, 64, credits returned per update

Ports:
- clk  in  1  interface clock; all logic is on the rising edge
- reset  in  1  synchronous, active-low
- din_leaf_user2interface  in  NUM_OUT_PORTS*32  payload; port i occupies bits [32i+31:32i]
- vld_user2interface  in  NUM_OUT_PORTS  per-port word valid
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept pulse
- dout_leaf_interface2bft  out  49  packet; bit 48 is the valid bit
- bft_rdy  in  1  BFT accepts the current packet this cycle
- resend  in  1  freeze: no grants, dout forced to 0
- cfg_vld  in  1  config write strobe
- cfg_port  in  4  output port index being configured
- cfg_leaf  in  5  destination leaf
- cfg_dport  in  4  destination port
- upd_vld  in  1  credit-return strobe
- upd_port  in  4  output port receiving +FREESPACE_UPDATE_SIZE credits

## Operation
Packet format:
- [48] valid
- [47:43] dest leaf
- [42:39] dest port
- [38:32] address
- [31:0] payload

Per-port state:
- en[i]: set by cfg write, cleared by reset.
- leaf[i], dport[i]: written by cfg write.
- credit[i]: 8 bits, range 0..128, reset value 128.
- addr[i]: 7 bits, reset value 0.
- A cfg write with cfg_port ≥ NUM_OUT_PORTS is ignored. A cfg write to a port also re-initialises credit = 128 and addr = 0.

Eligibility: port i is eligible when en[i] & vld_user2interface[i] & credit[i] != 0.

Output register states:
- EMPTY: dout[48] = 0.
- FULL: dout[48] = 1. A packet is held until bft_rdy = 1.

Grant:
- Allowed in a cycle when resend = 0 and the register is (EMPTY, or FULL with bft_rdy = 1).
- Round-robin: the search starts at ptr+1 modulo NUM_OUT_PORTS. The first eligible port wins and ptr is set to the winner.
- On a grant to port i:
  - ack_interface2user[i] = 1 in that cycle (combinational from the registered state and vld).
  - The packet {1, leaf[i], dport[i], addr[i], payload[i]} is loaded into the output register.
  - addr[i] increments, wrapping 127 → 0.
  - credit[i] decrements by 1.
- FULL with bft_rdy = 1 and no grant → EMPTY.
- At most one ack bit is high per cycle.

Credits:
- upd_vld adds FREESPACE_UPDATE_SIZE to credit[upd_port], saturating at 128.
- A decrement and an update to the same port in the same cycle give a net +63 (still saturating at 128).
- upd_port ≥ NUM_OUT_PORTS is ignored.

Resend:
- While resend = 1: no grants, all acks = 0, dout = 0.
- The held packet and all counters are preserved. It is presented again the cycle after resend falls.

Reset (reset = 0 at a rising edge):
- Output register EMPTY, dout = 0, ack = 0.
- ptr = NUM_OUT_PORTS-1, so port 0 has first priority.
- en = 0, credit = 128, addr = 0, leaf and dport = 0.
- Reset asserted mid-transfer discards the held packet; nothing is replayed.

## Timing
- Latency: word valid in cycle t with a grant → ack high in cycle t, packet on dout from cycle t+1.
- Throughput: 1 packet per cycle while bft_rdy = 1.
- A user holds vld and data until ack. The word is consumed at the edge ending the ack cycle.
- A cfg write takes effect the next cycle. A port enabled at edge t can be granted in cycle t+1.
- A credit update at edge t unblocks a port with zero credit in cycle t+1.
- dout and the internal state are registered. ack is the only combinational output.

## Test plan
- Reset, cfg port0 → (leaf 3, dport 2), vld0 = 1 with data 0xDEADBEEF, bft_rdy = 1 → ack0 one cycle; next cycle dout = {1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}.
- Both ports enabled, both vld held continuously, bft_rdy = 1 → grants alternate 0, 1, 0, 1…; the addr fields of each port count 0, 1, 2…
- Send 128 words on port 0 with no updates → 129th word gets no ack. Assert upd_vld with upd_port = 0 → ack resumes next cycle, and exactly 64 more words are sent.
- 130 words across updates → addr field wraps 127 → 0.
- bft_rdy = 0 with a packet held → dout stable and no ack for 5 cycles; bft_rdy = 1 → next packet is granted in the same cycle.
- resend = 1 mid-stream for 3 cycles → dout = 0 and no acks; after release, the held packet reappears unchanged.
- Reset asserted during back-to-back traffic → next cycle dout = 0, all acks 0, all ports disabled until reconfigured.
